map_table: RTL and testbench
============================

Name: map_table

Overview:
- Register-rename map table for a 2-wide out-of-order core; sits between dispatch (ROB/free list) and the reservation stations.
- Holds one entry per architectural register: the current physical register (PR) tag and a ready bit.
- Each cycle it renames up to two destinations and reports the old tags (Told) to the ROB.
- Each cycle it looks up four source operands for the RS and sets ready bits from CDB broadcasts.

Parameters:
- CDB_WIDTH, 4, number of CDB broadcast lanes
- AR_NUM, 32, number of architectural registers (5-bit index)
- PR_W, 7, physical register tag width

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-low reset
- rob_dispatch_num  in  2  instructions dispatched this cycle (0..2)
- fl_pr0, fl_pr1  in  7  new PRs from the free list for instructions a and b
- rob_ar_a_valid, rob_ar_b_valid  in  1  destination valid for instructions a and b
- rob_ar_a, rob_ar_b  in  5  destination ARs for instructions a and b
- rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid  in  1  source-operand valid
- rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2  in  5  source ARs
- cdb_broadcast  in  CDB_WIDTH  per-lane broadcast valid
- cdb_pr_tag0..3  in  7  broadcast PR tag per lane
- cdb_ar_tag0..3  in  5  broadcast AR per lane
- rob_p0told, rob_p1told  out  7  previous mapping of rob_ar_a and rob_ar_b
- rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2  out  7  source PR tags
- rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready  out  1  source ready flags

Behaviour:
- State: map[32] of 7 bits and rdy[32].
- Reset: on a rising edge with reset==0, map[i]=i and rdy[i]=1 for all i. Reset overrides dispatch and CDB.
- All outputs are combinational from the current state and the current inputs, with zero latency. No output registers.
- Outputs always reflect the lookups, whether or not the corresponding valid bit is set.
- Rename enables:
  - enA = rob_ar_a_valid && rob_dispatch_num>=1.
  - enB = rob_ar_b_valid && rob_dispatch_num==2.
  - rob_dispatch_num==3 is treated as 2.
- Source lookups for a (a1, a2): rs_pr = map[ar]; ready = rdy[ar] OR (some lane k has cdb_broadcast[k] with cdb_pr_tag_k == map[ar]).
- Source lookups for b (b1, b2):
  - If enA and the AR equals rob_ar_a: output fl_pr0 with ready=0 (intra-group dependency).
  - Otherwise, same as for a.
- Told outputs:
  - rob_p0told = map[rob_ar_a].
  - rob_p1told = fl_pr0 if enA and rob_ar_b==rob_ar_a; otherwise map[rob_ar_b].
- Update on the rising edge when reset is high, applied in this priority order (lowest first):
  1. CDB: for each lane k with cdb_broadcast[k], if map[cdb_ar_tag_k]==cdb_pr_tag_k then rdy[cdb_ar_tag_k]<=1. A stale tag (mapping already changed) is ignored.
  2. enA: map[rob_ar_a]<=fl_pr0, rdy<=0.
  3. enB: map[rob_ar_b]<=fl_pr1, rdy<=0. Rename b overrides rename a and CDB on the same AR.
- Multiple CDB lanes targeting the same AR are harmless (all set rdy).
- Free-list tags are trusted: no checking of fl_pr0/fl_pr1.

Decomposition:
- Shared package: CDB_WIDTH (=4), AR_NUM, AR_W=5, PR_W=7, and the pr_tag/ar_idx typedefs.
- One sub-module, map_table_lookup: a single read port containing the table mux plus CDB-bypass ready logic, instantiated 6 times (4 sources + 2 Told).

Test Plan:
- Reset low for 2 cycles, then read all 32 ARs in groups of four (a1=i, a2=i+1, b1=i+2, b2=i+3) -> rs_pr equals the AR index, ready=1.
- Dispatch 2 with a=i, b=i+1, fl_pr0=i+32, fl_pr1=i+33 for i=0,2,…,30 -> Told=i and i+1. Next cycle, dispatch_num=1 reading a1=i, a2=i+1 -> i+32 and i+33, ready=0.
- After AR5 is mapped to PR37: CDB lane 2 broadcasts pr 37, ar 5 -> same-cycle lookup of AR5 gives ready=1; the bit stays ready next cycle. A broadcast of pr 5 for ar 5 is ignored.
- Same cycle: a=3 gets fl_pr0=40; b=3 gets fl_pr1=41; b1=3 -> rs_pr_b1=40 with ready=0, rob_p1told=40. Next cycle map[3]=41.
- dispatch_num=1 with b valid (rob_ar_b=7) -> map[7] is unchanged.
- Assert reset mid-stream after renames -> identity mapping and all ready on the next cycle.

Source files
------------

// File: rtl/map_table_pkg.sv
// Shared sizes and tag types for the register-rename map table.
package map_table_pkg;
    localparam int CDB_WIDTH = 4;
    localparam int AR_NUM    = 32;
    localparam int AR_W      = 5;
    localparam int PR_W      = 7;

    typedef logic [PR_W-1:0] pr_tag;
    typedef logic [AR_W-1:0] ar_idx;
endpackage

// File: rtl/map_table_lookup.sv
// One read port of the map table: table mux, intra-group bypass and CDB ready bypass.
module map_table_lookup
    import map_table_pkg::*;
(
    input  logic [AR_NUM-1:0][PR_W-1:0]    map,
    input  logic [AR_NUM-1:0]              rdy,
    input  logic [AR_W-1:0]                ar,
    input  logic                           bypass_valid,
    input  logic [AR_W-1:0]                bypass_ar,
    input  logic [PR_W-1:0]                bypass_tag,
    input  logic [CDB_WIDTH-1:0]           cdb_broadcast,
    input  logic [CDB_WIDTH-1:0][PR_W-1:0] cdb_pr_tag,
    output logic [PR_W-1:0]                pr,
    output logic                           ready
);
    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++)
            hit = hit | (cdb_broadcast[k] && (cdb_pr_tag[k] == map[ar]));

        // An older instruction in the same group writes this AR: its new tag is not produced yet.
        if (bypass_valid && (ar == bypass_ar)) begin
            pr    = bypass_tag;
            ready = 1'b0;
        end else begin
            pr    = map[ar];
            ready = rdy[ar] | hit;
        end
    end
endmodule

// File: rtl/map_table.sv
// Rename map table for a 2-wide core: two renames, four source lookups and CDB wakeup per cycle.
module map_table
    import map_table_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rob_dispatch_num,
    input  logic [6:0] fl_pr0,
    input  logic [6:0] fl_pr1,
    input  logic       rob_ar_a_valid,
    input  logic       rob_ar_b_valid,
    input  logic [4:0] rob_ar_a,
    input  logic [4:0] rob_ar_b,
    input  logic       rob_ar_a1_valid,
    input  logic       rob_ar_a2_valid,
    input  logic       rob_ar_b1_valid,
    input  logic       rob_ar_b2_valid,
    input  logic [4:0] rob_ar_a1,
    input  logic [4:0] rob_ar_a2,
    input  logic [4:0] rob_ar_b1,
    input  logic [4:0] rob_ar_b2,
    input  logic [3:0] cdb_broadcast,
    input  logic [6:0] cdb_pr_tag0,
    input  logic [6:0] cdb_pr_tag1,
    input  logic [6:0] cdb_pr_tag2,
    input  logic [6:0] cdb_pr_tag3,
    input  logic [4:0] cdb_ar_tag0,
    input  logic [4:0] cdb_ar_tag1,
    input  logic [4:0] cdb_ar_tag2,
    input  logic [4:0] cdb_ar_tag3,
    output logic [6:0] rob_p0told,
    output logic [6:0] rob_p1told,
    output logic [6:0] rs_pr_a1,
    output logic [6:0] rs_pr_a2,
    output logic [6:0] rs_pr_b1,
    output logic [6:0] rs_pr_b2,
    output logic       rs_pr_a1_ready,
    output logic       rs_pr_a2_ready,
    output logic       rs_pr_b1_ready,
    output logic       rs_pr_b2_ready
);
    logic [AR_NUM-1:0][PR_W-1:0] map;
    logic [AR_NUM-1:0]           rdy;

    logic en_a, en_b;
    logic [CDB_WIDTH-1:0][PR_W-1:0] cdb_pr;
    logic [CDB_WIDTH-1:0][AR_W-1:0] cdb_ar;

    // Source-operand enables are only meaningful to the RS; lookups run regardless.
    logic [3:0] src_valid_unused;

    assign en_a   = rob_ar_a_valid && (rob_dispatch_num != 2'd0);
    assign en_b   = rob_ar_b_valid && rob_dispatch_num[1];
    assign cdb_pr = {cdb_pr_tag3, cdb_pr_tag2, cdb_pr_tag1, cdb_pr_tag0};
    assign cdb_ar = {cdb_ar_tag3, cdb_ar_tag2, cdb_ar_tag1, cdb_ar_tag0};
    assign src_valid_unused = {rob_ar_b2_valid, rob_ar_b1_valid, rob_ar_a2_valid, rob_ar_a1_valid};

    logic [3:0][AR_W-1:0] src_ar;
    logic [3:0]           src_byp;
    logic [3:0][PR_W-1:0] src_pr;
    logic [3:0]           src_ready;

    assign src_ar  = {rob_ar_b2, rob_ar_b1, rob_ar_a2, rob_ar_a1};
    assign src_byp = {en_a, en_a, 1'b0, 1'b0};

    for (genvar g = 0; g < 4; g++) begin : g_src
        map_table_lookup u_lookup (
            .map           (map),
            .rdy           (rdy),
            .ar            (src_ar[g]),
            .bypass_valid  (src_byp[g]),
            .bypass_ar     (rob_ar_a),
            .bypass_tag    (fl_pr0),
            .cdb_broadcast (cdb_broadcast),
            .cdb_pr_tag    (cdb_pr),
            .pr            (src_pr[g]),
            .ready         (src_ready[g])
        );
    end

    logic [1:0][AR_W-1:0] told_ar;
    logic [1:0]           told_byp;
    logic [1:0][PR_W-1:0] told_pr;
    logic [1:0]           told_ready_unused;

    assign told_ar  = {rob_ar_b, rob_ar_a};
    assign told_byp = {en_a, 1'b0};

    for (genvar g = 0; g < 2; g++) begin : g_told
        map_table_lookup u_lookup (
            .map           (map),
            .rdy           (rdy),
            .ar            (told_ar[g]),
            .bypass_valid  (told_byp[g]),
            .bypass_ar     (rob_ar_a),
            .bypass_tag    (fl_pr0),
            .cdb_broadcast (cdb_broadcast),
            .cdb_pr_tag    (cdb_pr),
            .pr            (told_pr[g]),
            .ready         (told_ready_unused[g])
        );
    end

    assign rs_pr_a1       = src_pr[0];
    assign rs_pr_a2       = src_pr[1];
    assign rs_pr_b1       = src_pr[2];
    assign rs_pr_b2       = src_pr[3];
    assign rs_pr_a1_ready = src_ready[0];
    assign rs_pr_a2_ready = src_ready[1];
    assign rs_pr_b1_ready = src_ready[2];
    assign rs_pr_b2_ready = src_ready[3];
    assign rob_p0told     = told_pr[0];
    assign rob_p1told     = told_pr[1];

    // Later assignments win: CDB wakeup, then rename a, then rename b.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < AR_NUM; i++) begin
                map[i] <= pr_tag'(i);
                rdy[i] <= 1'b1;
            end
        end else begin
            for (int k = 0; k < CDB_WIDTH; k++)
                if (cdb_broadcast[k] && (map[cdb_ar[k]] == cdb_pr[k]))
                    rdy[cdb_ar[k]] <= 1'b1;
            if (en_a) begin
                map[rob_ar_a] <= fl_pr0;
                rdy[rob_ar_a] <= 1'b0;
            end
            if (en_b) begin
                map[rob_ar_b] <= fl_pr1;
                rdy[rob_ar_b] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: behavioural table model checked every cycle plus literal spot checks.
module tb_map_table;
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] rob_dispatch_num;
    logic [6:0] fl_pr0, fl_pr1;
    logic       rob_ar_a_valid, rob_ar_b_valid;
    logic [4:0] rob_ar_a, rob_ar_b;
    logic       rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid;
    logic [4:0] rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2;
    logic [3:0] cdb_broadcast;
    logic [6:0] cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
    logic [4:0] cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;
    logic [6:0] rob_p0told, rob_p1told;
    logic [6:0] rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2;
    logic       rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready;

    map_table dut (
        .clock(clock), .reset(reset), .rob_dispatch_num(rob_dispatch_num),
        .fl_pr0(fl_pr0), .fl_pr1(fl_pr1),
        .rob_ar_a_valid(rob_ar_a_valid), .rob_ar_b_valid(rob_ar_b_valid),
        .rob_ar_a(rob_ar_a), .rob_ar_b(rob_ar_b),
        .rob_ar_a1_valid(rob_ar_a1_valid), .rob_ar_a2_valid(rob_ar_a2_valid),
        .rob_ar_b1_valid(rob_ar_b1_valid), .rob_ar_b2_valid(rob_ar_b2_valid),
        .rob_ar_a1(rob_ar_a1), .rob_ar_a2(rob_ar_a2), .rob_ar_b1(rob_ar_b1), .rob_ar_b2(rob_ar_b2),
        .cdb_broadcast(cdb_broadcast),
        .cdb_pr_tag0(cdb_pr_tag0), .cdb_pr_tag1(cdb_pr_tag1),
        .cdb_pr_tag2(cdb_pr_tag2), .cdb_pr_tag3(cdb_pr_tag3),
        .cdb_ar_tag0(cdb_ar_tag0), .cdb_ar_tag1(cdb_ar_tag1),
        .cdb_ar_tag2(cdb_ar_tag2), .cdb_ar_tag3(cdb_ar_tag3),
        .rob_p0told(rob_p0told), .rob_p1told(rob_p1told),
        .rs_pr_a1(rs_pr_a1), .rs_pr_a2(rs_pr_a2), .rs_pr_b1(rs_pr_b1), .rs_pr_b2(rs_pr_b2),
        .rs_pr_a1_ready(rs_pr_a1_ready), .rs_pr_a2_ready(rs_pr_a2_ready),
        .rs_pr_b1_ready(rs_pr_b1_ready), .rs_pr_b2_ready(rs_pr_b2_ready)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the architectural->physical table and its ready bits.
    int m_map[32];
    bit m_rdy[32];
    bit model_valid = 0;

    function automatic int cdb_pr(input int k);
        case (k)
            0: return int'(cdb_pr_tag0);
            1: return int'(cdb_pr_tag1);
            2: return int'(cdb_pr_tag2);
            default: return int'(cdb_pr_tag3);
        endcase
    endfunction

    function automatic int cdb_ar(input int k);
        case (k)
            0: return int'(cdb_ar_tag0);
            1: return int'(cdb_ar_tag1);
            2: return int'(cdb_ar_tag2);
            default: return int'(cdb_ar_tag3);
        endcase
    endfunction

    function automatic bit en_a();
        return rob_ar_a_valid && rob_dispatch_num >= 1;
    endfunction

    function automatic bit en_b();
        return rob_ar_b_valid && rob_dispatch_num >= 2;
    endfunction

    function automatic bit woken(input int tag);
        for (int k = 0; k < 4; k++)
            if (cdb_broadcast[k] && cdb_pr(k) == tag) return 1;
        return 0;
    endfunction

    function automatic int exp_pr(input int ar, input bit b_side);
        if (b_side && en_a() && ar == int'(rob_ar_a)) return int'(fl_pr0);
        return m_map[ar];
    endfunction

    function automatic int exp_rdy(input int ar, input bit b_side);
        if (b_side && en_a() && ar == int'(rob_ar_a)) return 0;
        return int'(m_rdy[ar] || woken(m_map[ar]));
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_map[i] = i;
                m_rdy[i] = 1;
            end
            model_valid = 1;
        end else if (model_valid) begin
            bit [31:0] wake;
            wake = '0;
            for (int k = 0; k < 4; k++)
                if (cdb_broadcast[k] && m_map[cdb_ar(k)] == cdb_pr(k)) wake[cdb_ar(k)] = 1;
            for (int i = 0; i < 32; i++)
                if (wake[i]) m_rdy[i] = 1;
            if (en_a()) begin m_map[rob_ar_a] = fl_pr0; m_rdy[rob_ar_a] = 0; end
            if (en_b()) begin m_map[rob_ar_b] = fl_pr1; m_rdy[rob_ar_b] = 0; end
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("mdl_a1",     rs_pr_a1,       exp_pr(rob_ar_a1, 0));
            check("mdl_a2",     rs_pr_a2,       exp_pr(rob_ar_a2, 0));
            check("mdl_b1",     rs_pr_b1,       exp_pr(rob_ar_b1, 1));
            check("mdl_b2",     rs_pr_b2,       exp_pr(rob_ar_b2, 1));
            check("mdl_a1_rdy", rs_pr_a1_ready, exp_rdy(rob_ar_a1, 0));
            check("mdl_a2_rdy", rs_pr_a2_ready, exp_rdy(rob_ar_a2, 0));
            check("mdl_b1_rdy", rs_pr_b1_ready, exp_rdy(rob_ar_b1, 1));
            check("mdl_b2_rdy", rs_pr_b2_ready, exp_rdy(rob_ar_b2, 1));
            check("mdl_p0told", rob_p0told,     m_map[rob_ar_a]);
            check("mdl_p1told", rob_p1told,
                  (en_a() && rob_ar_b == rob_ar_a) ? int'(fl_pr0) : m_map[rob_ar_b]);
        end
    end

    task automatic idle();
        rob_dispatch_num = 0; fl_pr0 = 0; fl_pr1 = 0;
        rob_ar_a_valid = 0; rob_ar_b_valid = 0; rob_ar_a = 0; rob_ar_b = 0;
        rob_ar_a1_valid = 1; rob_ar_a2_valid = 1; rob_ar_b1_valid = 1; rob_ar_b2_valid = 1;
        rob_ar_a1 = 0; rob_ar_a2 = 0; rob_ar_b1 = 0; rob_ar_b2 = 0;
        cdb_broadcast = 0;
        cdb_pr_tag0 = 0; cdb_pr_tag1 = 0; cdb_pr_tag2 = 0; cdb_pr_tag3 = 0;
        cdb_ar_tag0 = 0; cdb_ar_tag1 = 0; cdb_ar_tag2 = 0; cdb_ar_tag3 = 0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        reset = 0;
        idle();
        repeat (2) @(posedge clock);
        #1 reset = 1;

        // identity mapping after reset
        for (int i = 0; i < 32; i += 4) begin
            rob_ar_a1 = 5'(i); rob_ar_a2 = 5'(i + 1); rob_ar_b1 = 5'(i + 2); rob_ar_b2 = 5'(i + 3);
            @(negedge clock);
            check("rst_a1", rs_pr_a1, i);
            check("rst_b2", rs_pr_b2, i + 3);
            check("rst_rdy", rs_pr_a1_ready & rs_pr_b2_ready, 1);
            next();
        end

        // rename every AR, then read back the new tags
        for (int i = 0; i < 32; i += 2) begin
            rob_dispatch_num = 2; rob_ar_a_valid = 1; rob_ar_b_valid = 1;
            rob_ar_a = 5'(i); rob_ar_b = 5'(i + 1); fl_pr0 = 7'(i + 32); fl_pr1 = 7'(i + 33);
            @(negedge clock);
            check("ren_p0told", rob_p0told, i);
            check("ren_p1told", rob_p1told, i + 1);
            next();
            rob_dispatch_num = 1; rob_ar_a1 = 5'(i); rob_ar_a2 = 5'(i + 1);
            @(negedge clock);
            check("ren_a1", rs_pr_a1, i + 32);
            check("ren_a2", rs_pr_a2, i + 33);
            check("ren_rdy", rs_pr_a1_ready | rs_pr_a2_ready, 0);
            next();
        end

        // stale broadcast for AR5 (pr 5) is ignored
        cdb_broadcast = 4'b0001; cdb_pr_tag0 = 5; cdb_ar_tag0 = 5; rob_ar_a1 = 5;
        @(negedge clock); check("stale_byp", rs_pr_a1_ready, 0);
        next();
        rob_ar_a1 = 5;
        @(negedge clock); check("stale_state", rs_pr_a1_ready, 0);
        next();
        // live broadcast on lane 2 wakes AR5 in the same cycle and stays set
        cdb_broadcast = 4'b0100; cdb_pr_tag2 = 37; cdb_ar_tag2 = 5; rob_ar_a1 = 5; rob_ar_b2 = 5;
        @(negedge clock);
        check("cdb_byp_a1", rs_pr_a1_ready, 1);
        check("cdb_byp_pr", rs_pr_a1, 37);
        check("cdb_byp_b2", rs_pr_b2_ready, 1);
        next();
        rob_ar_a1 = 5;
        @(negedge clock); check("cdb_held", rs_pr_a1_ready, 1);
        next();

        // a and b both rename AR3 in one group
        rob_dispatch_num = 2; rob_ar_a_valid = 1; rob_ar_b_valid = 1;
        rob_ar_a = 3; rob_ar_b = 3; fl_pr0 = 40; fl_pr1 = 41; rob_ar_b1 = 3;
        @(negedge clock);
        check("grp_b1", rs_pr_b1, 40);
        check("grp_b1_rdy", rs_pr_b1_ready, 0);
        check("grp_p0told", rob_p0told, 35);
        check("grp_p1told", rob_p1told, 40);
        next();
        rob_ar_a1 = 3;
        @(negedge clock); check("grp_after", rs_pr_a1, 41);
        next();

        // dispatch 1 ignores b; a still renames
        rob_dispatch_num = 1; rob_ar_b_valid = 1; rob_ar_b = 7; fl_pr1 = 99;
        rob_ar_a_valid = 1; rob_ar_a = 9; fl_pr0 = 50;
        @(negedge clock);
        next();
        rob_ar_a1 = 7; rob_ar_a2 = 9;
        @(negedge clock);
        check("d1_b_ign", rs_pr_a1, 39);
        check("d1_a_ren", rs_pr_a2, 50);
        next();

        // rename beats a live CDB wakeup on the same AR
        rob_dispatch_num = 1; rob_ar_a_valid = 1; rob_ar_a = 10; fl_pr0 = 60;
        cdb_broadcast = 4'b0010; cdb_pr_tag1 = 42; cdb_ar_tag1 = 10;
        @(negedge clock);
        next();
        rob_ar_a1 = 10;
        @(negedge clock);
        check("ren_vs_cdb_pr", rs_pr_a1, 60);
        check("ren_vs_cdb_rdy", rs_pr_a1_ready, 0);
        next();

        // dispatch 3 behaves as 2
        rob_dispatch_num = 3; rob_ar_a_valid = 1; rob_ar_b_valid = 1;
        rob_ar_a = 12; rob_ar_b = 13; fl_pr0 = 70; fl_pr1 = 71;
        @(negedge clock);
        next();
        rob_ar_a1 = 12; rob_ar_a2 = 13;
        @(negedge clock);
        check("d3_a", rs_pr_a1, 70);
        check("d3_b", rs_pr_a2, 71);
        next();

        // reset overrides a concurrent dispatch
        reset = 0;
        rob_dispatch_num = 2; rob_ar_a_valid = 1; rob_ar_b_valid = 1;
        rob_ar_a = 0; rob_ar_b = 1; fl_pr0 = 80; fl_pr1 = 81;
        @(posedge clock);
        #1 reset = 1;
        idle();
        rob_ar_a1 = 0; rob_ar_a2 = 1; rob_ar_b1 = 3; rob_ar_b2 = 10;
        @(negedge clock);
        check("rst2_a1", rs_pr_a1, 0);
        check("rst2_a2", rs_pr_a2, 1);
        check("rst2_b1", rs_pr_b1, 3);
        check("rst2_b2", rs_pr_b2, 10);
        check("rst2_rdy", rs_pr_a1_ready & rs_pr_a2_ready & rs_pr_b1_ready & rs_pr_b2_ready, 1);
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
